// File: rtl/lic_pkg.sv
// Shared definitions for the LIC machine timer: register map, control bit
// positions, per-channel write strobes and the counter-width legality check.
package lic_pkg;

    // Word indices (byte offset >> 2) of the global registers.
    localparam logic [5:0] W_MTIME_LO = 6'h00;
    localparam logic [5:0] W_MTIME_HI = 6'h01;
    localparam logic [5:0] W_CTRL     = 6'h02;
    localparam logic [5:0] W_PEND     = 6'h03;

    // Channel i occupies the 16-byte block addr[7:4] == CH_BLK_BASE + i.
    localparam logic [3:0] CH_BLK_BASE = 4'h1;

    // Register selected by addr[3:2] inside a channel block.
    typedef enum logic [1:0] {
        CH_CMP_LO = 2'd0,
        CH_CMP_HI = 2'd1,
        CH_CTRL   = 2'd2,
        CH_PERIOD = 2'd3
    } ch_reg_e;

    // CTRL fields.
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_PRESC_LSB = 8;

    // CH_CTRL fields.
    localparam int CH_EN_BIT       = 0;
    localparam int CH_PERIODIC_BIT = 1;

    // Decoded bus write strobes delivered to one compare channel.
    typedef struct packed {
        logic cmp_lo;
        logic cmp_hi;
        logic ctrl;
        logic period;
        logic pend_clr;
    } ch_wr_t;

    // The counter is accessed as exactly two bus words, so it must be wider
    // than one word and no wider than two.
    function automatic bit timer_w_ok(int xlen, int tw);
        return (tw > xlen) && (tw <= 2 * xlen);
    endfunction

endpackage

// File: rtl/lic_cmp_chan.sv
// One compare channel: compare value, reload period, channel control,
// sticky pending flag, comparator, reload adder and registered irq.
module lic_cmp_chan
    import lic_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMER_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  ch_wr_t             wr_i,
    input  logic [XLEN-1:0]    wdata_i,
    input  logic [TIMER_W-1:0] mtime_i,
    output logic [TIMER_W-1:0] cmp_o,
    output logic [XLEN-1:0]    period_o,
    output logic               ch_en_o,
    output logic               periodic_o,
    output logic               pend_o,
    output logic               irq_d_o,
    output logic               irq_o
);

    localparam int HI_W = TIMER_W - XLEN;

    logic [TIMER_W-1:0] cmp_q, cmp_d;
    logic [XLEN-1:0]    period_q;
    logic               ch_en_q, periodic_q;
    logic               pend_q, pend_d;
    logic               irq_q;
    logic               match, reload;

    assign match  = ch_en_q && (mtime_i >= cmp_q);
    assign reload = periodic_q && match;

    // Compare value: a bus write to either half beats the periodic reload;
    // the half not being written keeps its current value.
    always_comb begin
        cmp_d = cmp_q;
        if (wr_i.cmp_lo || wr_i.cmp_hi) begin
            if (wr_i.cmp_lo) cmp_d[XLEN-1:0]       = wdata_i;
            if (wr_i.cmp_hi) cmp_d[TIMER_W-1:XLEN] = wdata_i[HI_W-1:0];
        end else if (reload) begin
            cmp_d = cmp_q + {{HI_W{1'b0}}, period_q};
        end
    end

    // Pending flag only lives in periodic mode; a match beats a same-cycle W1C.
    always_comb begin
        pend_d = pend_q;
        if (wr_i.pend_clr) pend_d = 1'b0;
        if (reload)        pend_d = 1'b1;
        if (!periodic_q)   pend_d = 1'b0;
    end

    // One-shot channels report the raw match level, periodic ones the flag.
    assign pend_o  = periodic_q ? pend_q : match;
    assign irq_d_o = pend_o;

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q      <= '1;
            period_q   <= '0;
            ch_en_q    <= 1'b0;
            periodic_q <= 1'b0;
            pend_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            cmp_q  <= cmp_d;
            pend_q <= pend_d;
            irq_q  <= irq_d_o;
            if (wr_i.period) period_q <= wdata_i;
            if (wr_i.ctrl) begin
                ch_en_q    <= wdata_i[CH_EN_BIT];
                periodic_q <= wdata_i[CH_PERIODIC_BIT];
            end
        end
    end

    assign cmp_o      = cmp_q;
    assign period_o   = period_q;
    assign ch_en_o    = ch_en_q;
    assign periodic_o = periodic_q;
    assign irq_o      = irq_q;

endmodule

// File: rtl/lic_mtimer.sv
// Machine timer for the local interrupt controller: prescaled free-running
// mtime, register decode, registered read mux and N_CMP compare channels.
module lic_mtimer
    import lic_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMER_W = 64,
    parameter int N_CMP   = 4,
    parameter int PRESC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             we,
    input  logic [7:0]       addr,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  rdata,
    input  logic             halt,
    output logic [N_CMP-1:0] timer_irq,
    output logic             timer_irq_any
);

    if (!timer_w_ok(XLEN, TIMER_W) || (N_CMP < 1) || (N_CMP > 8)
        || (CTRL_PRESC_LSB + PRESC_W > XLEN)) begin : g_bad_cfg
        $error("lic_mtimer: illegal XLEN/TIMER_W/N_CMP/PRESC_W combination");
    end

    logic [TIMER_W-1:0] mtime_q, mtime_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [PRESC_W-1:0] presc_q;
    logic               en_q;
    logic               tick;
    logic [XLEN-1:0]    rdata_q, rd_val;
    logic               any_q;

    logic               wr_acc, rd_acc;
    logic [5:0]         word;
    logic               wr_mtime_lo, wr_mtime_hi, wr_ctrl, wr_pend;

    logic [N_CMP-1:0][TIMER_W-1:0] cmp_v;
    logic [N_CMP-1:0][XLEN-1:0]    period_v;
    logic [N_CMP-1:0]              chen_v, per_v, pend_v, irq_d_v, irq_v;

    assign wr_acc = sel && we;
    assign rd_acc = sel && !we;
    assign word   = addr[7:2];

    assign wr_mtime_lo = wr_acc && (word == W_MTIME_LO);
    assign wr_mtime_hi = wr_acc && (word == W_MTIME_HI);
    assign wr_ctrl     = wr_acc && (word == W_CTRL);
    assign wr_pend     = wr_acc && (word == W_PEND);

    // Prescaler and counter: a tick fires when pcnt reaches presc; bus writes
    // to either mtime half override the increment and freeze the other half.
    always_comb begin
        tick    = en_q && !halt && (pcnt_q == presc_q);
        pcnt_d  = pcnt_q;
        mtime_d = mtime_q;
        if (en_q && !halt) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
        if (wr_ctrl)       pcnt_d = '0;
        if (tick)          mtime_d = mtime_q + TIMER_W'(1);
        if (wr_mtime_lo)   mtime_d = {mtime_q[TIMER_W-1:XLEN], wdata};
        if (wr_mtime_hi)   mtime_d = {wdata[TIMER_W-XLEN-1:0], mtime_q[XLEN-1:0]};
    end

    // Time base and global control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime_q <= '0;
            pcnt_q  <= '0;
            en_q    <= 1'b1;
            presc_q <= '0;
        end else begin
            mtime_q <= mtime_d;
            pcnt_q  <= pcnt_d;
            if (wr_ctrl) begin
                en_q    <= wdata[CTRL_EN_BIT];
                presc_q <= wdata[CTRL_PRESC_LSB +: PRESC_W];
            end
        end
    end

    // Per-channel write decode and channel instances.
    for (genvar i = 0; i < N_CMP; i++) begin : g_ch
        ch_wr_t wr;
        logic   blk_hit;

        assign blk_hit = wr_acc && (addr[7:4] == CH_BLK_BASE + 4'(i));
        assign wr = '{
            cmp_lo:   blk_hit && (addr[3:2] == CH_CMP_LO),
            cmp_hi:   blk_hit && (addr[3:2] == CH_CMP_HI),
            ctrl:     blk_hit && (addr[3:2] == CH_CTRL),
            period:   blk_hit && (addr[3:2] == CH_PERIOD),
            pend_clr: wr_pend && wdata[i]
        };

        lic_cmp_chan #(
            .XLEN    (XLEN),
            .TIMER_W (TIMER_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (reset),
            .wr_i       (wr),
            .wdata_i    (wdata),
            .mtime_i    (mtime_q),
            .cmp_o      (cmp_v[i]),
            .period_o   (period_v[i]),
            .ch_en_o    (chen_v[i]),
            .periodic_o (per_v[i]),
            .pend_o     (pend_v[i]),
            .irq_d_o    (irq_d_v[i]),
            .irq_o      (irq_v[i])
        );
    end

    // Read mux: unmapped words and absent channels read as zero.
    always_comb begin
        rd_val = '0;
        case (word)
            W_MTIME_LO: rd_val = mtime_q[XLEN-1:0];
            W_MTIME_HI: rd_val = XLEN'(mtime_q[TIMER_W-1:XLEN]);
            W_CTRL: begin
                rd_val[CTRL_EN_BIT]                = en_q;
                rd_val[CTRL_PRESC_LSB +: PRESC_W]  = presc_q;
            end
            W_PEND:     rd_val = XLEN'(pend_v);
            default: begin
                for (int i = 0; i < N_CMP; i++) begin
                    if (addr[7:4] == CH_BLK_BASE + 4'(i)) begin
                        case (ch_reg_e'(addr[3:2]))
                            CH_CMP_LO: rd_val = cmp_v[i][XLEN-1:0];
                            CH_CMP_HI: rd_val = XLEN'(cmp_v[i][TIMER_W-1:XLEN]);
                            CH_CTRL: begin
                                rd_val[CH_EN_BIT]       = chen_v[i];
                                rd_val[CH_PERIODIC_BIT] = per_v[i];
                            end
                            default:   rd_val = period_v[i];
                        endcase
                    end
                end
            end
        endcase
    end

    // Read data holds until the next read; the OR line is registered from
    // the channels' next irq values so it lines up with timer_irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            any_q   <= 1'b0;
        end else begin
            if (rd_acc) rdata_q <= rd_val;
            any_q <= |irq_d_v;
        end
    end

    assign rdata         = rdata_q;
    assign timer_irq     = irq_v;
    assign timer_irq_any = any_q;

endmodule

// File: tb/tb_lic_mtimer.sv
// Randomized and directed bench for lic_mtimer against a behavioural model.
module tb_lic_mtimer;

    localparam int XL = 32;
    localparam int TW = 64;
    localparam int NC = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          sel = 1'b0;
    logic          we = 1'b0;
    logic [7:0]    addr = '0;
    logic [XL-1:0] wdata = '0;
    logic          halt = 1'b0;
    logic [XL-1:0] rdata;
    logic [NC-1:0] timer_irq;
    logic          timer_irq_any;

    int n_assert = 0;
    int n_fail   = 0;

    lic_mtimer #(.XLEN(XL), .TIMER_W(TW), .N_CMP(NC), .PRESC_W(PW)) dut (
        .clk           (clk),
        .reset         (reset),
        .sel           (sel),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .halt          (halt),
        .timer_irq     (timer_irq),
        .timer_irq_any (timer_irq_any)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [TW-1:0] m_mtime;
    int            m_pcnt, m_presc;
    bit            m_en;
    logic [TW-1:0] m_cmp [NC];
    logic [XL-1:0] m_period [NC];
    logic [NC-1:0] m_chen, m_per, m_pend, m_irq;
    bit            m_any;
    logic [XL-1:0] m_rdata;

    task automatic model_reset();
        m_mtime = '0; m_pcnt = 0; m_presc = 0; m_en = 1'b1;
        for (int i = 0; i < NC; i++) begin
            m_cmp[i] = '1; m_period[i] = '0;
        end
        m_chen = '0; m_per = '0; m_pend = '0; m_irq = '0; m_any = 1'b0;
        m_rdata = '0;
    endtask

    function automatic logic [XL-1:0] mread(int a, logic [NC-1:0] m);
        int ch, off;
        if (a == 0) return m_mtime[31:0];
        if (a == 4) return m_mtime[63:32];
        if (a == 8) return 32'(m_en) | 32'(m_presc << 8);
        if (a == 12) return 32'((m_per & m_pend) | (~m_per & m));
        if (a >= 16 && a < 16 + 16 * NC) begin
            ch  = a / 16 - 1;
            off = a % 16;
            case (off)
                0:       return m_cmp[ch][31:0];
                4:       return m_cmp[ch][63:32];
                8:       return {30'd0, m_per[ch], m_chen[ch]};
                default: return m_period[ch];
            endcase
        end
        return '0;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        logic [NC-1:0] m;
        logic [TW-1:0] old_t;
        bit            tick, cw;
        int            a, ch;
        if (!reset) return;
        a = int'(addr) & 'hFC;
        old_t = m_mtime;
        for (int i = 0; i < NC; i++) m[i] = m_chen[i] && (m_mtime >= m_cmp[i]);
        for (int i = 0; i < NC; i++) m_irq[i] = m_per[i] ? m_pend[i] : m[i];
        m_any = |m_irq;
        if (sel && !we) m_rdata = mread(a, m);
        tick = 1'b0;
        if (m_en && !halt) begin
            if (m_pcnt == m_presc) begin tick = 1'b1; m_pcnt = 0; end
            else m_pcnt++;
        end
        if (tick) m_mtime = m_mtime + 1;
        for (int i = 0; i < NC; i++) begin
            cw = sel && we && (a == 16 + 16 * i || a == 20 + 16 * i);
            if (!m_per[i]) m_pend[i] = 1'b0;
            else begin
                if (sel && we && a == 12 && wdata[i]) m_pend[i] = 1'b0;
                if (m[i]) begin
                    m_pend[i] = 1'b1;
                    if (!cw) m_cmp[i] = m_cmp[i] + {32'd0, m_period[i]};
                end
            end
        end
        if (sel && we) begin
            case (a)
                0: m_mtime = {old_t[63:32], wdata};
                4: m_mtime = {wdata, old_t[31:0]};
                8: begin m_en = wdata[0]; m_presc = int'(wdata[15:8]); m_pcnt = 0; end
                default: if (a >= 16 && a < 16 + 16 * NC) begin
                    ch = a / 16 - 1;
                    case (a % 16)
                        0:  m_cmp[ch][31:0]  = wdata;
                        4:  m_cmp[ch][63:32] = wdata;
                        8:  begin m_chen[ch] = wdata[0]; m_per[ch] = wdata[1]; end
                        default: m_period[ch] = wdata;
                    endcase
                end
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("rdata", 64'(rdata), 64'(m_rdata));
        chk("timer_irq", 64'(timer_irq), 64'(m_irq));
        chk("timer_irq_any", 64'(timer_irq_any), 64'(m_any));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit s, input bit w, input logic [7:0] a, input logic [XL-1:0] d);
        sel = s; we = w; addr = a; wdata = d;
        @(posedge clk);
        model_step();
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [XL-1:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        cyc(1'b1, 1'b0, a, '0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00, '0);
    endtask

    initial begin
        logic [7:0]    ra;
        logic [XL-1:0] rw;
        reset = 1'b0;
        model_reset();
        #1;
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_irq", 64'(timer_irq), 64'd0);
        #21 reset = 1'b1;

        // one-shot ch0, cmp = 5
        wr(8'h08, 32'h0);
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h0);
        wr(8'h10, 32'd5);
        wr(8'h14, 32'h0);
        wr(8'h18, 32'h1);
        wr(8'h08, 32'h1);
        idle(4);
        rd(8'h00);
        chk("mtime_at_5th_read", 64'(rdata), 64'd4);
        chk("irq0_before_match", 64'(timer_irq[0]), 64'd0);
        idle(1);
        chk("irq0_rise", 64'(timer_irq[0]), 64'd1);
        idle(3);
        chk("irq0_level_hold", 64'(timer_irq[0]), 64'd1);
        wr(8'h10, 32'd100);
        idle(1);
        chk("irq0_drop_after_cmp_raise", 64'(timer_irq[0]), 64'd0);

        // prescaler 3 and halt
        wr(8'h08, 32'h0000_0301);
        wr(8'h00, 32'd1000);
        rd(8'h00);
        chk("presc_mtime_a", 64'(rdata), 64'd1000);
        idle(5);
        rd(8'h00);
        chk("presc_mtime_b", 64'(rdata), 64'd1001);
        halt = 1'b1;
        rd(8'h00);
        idle(8);
        rd(8'h00);
        chk("halt_freeze", 64'(rdata), 64'd1002);
        halt = 1'b0;
        idle(3);
        rd(8'h00);
        chk("halt_pcnt_frozen", 64'(rdata), 64'd1002);
        rd(8'h00);
        chk("after_halt_tick", 64'(rdata), 64'd1003);
        wr(8'h08, 32'h1);

        // periodic ch1, cmp 10, period 8
        wr(8'h08, 32'h0);
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h0);
        wr(8'h20, 32'd10);
        wr(8'h24, 32'h0);
        wr(8'h2C, 32'd8);
        wr(8'h28, 32'h3);
        wr(8'h08, 32'h1);
        idle(13);
        rd(8'h20);
        chk("periodic_reload_18", 64'(rdata), 64'd18);
        wr(8'h0C, 32'h2);
        rd(8'h0C);
        chk("w1c_clears_pend", 64'(rdata), 64'd0);
        idle(2);
        wr(8'h0C, 32'h2);
        rd(8'h0C);
        chk("set_beats_w1c", 64'(rdata), 64'd2);
        rd(8'h20);
        chk("periodic_reload_26", 64'(rdata), 64'd26);

        // wrap of mtime against ch2 cmp = all-ones
        wr(8'h08, 32'h0);
        wr(8'h00, 32'hFFFF_FFFE);
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h30, 32'hFFFF_FFFF);
        wr(8'h34, 32'hFFFF_FFFF);
        wr(8'h38, 32'h1);
        wr(8'h08, 32'h1);
        chk("wrap_irq2_a", 64'(timer_irq[2]), 64'd0);
        idle(1);
        chk("wrap_irq2_b", 64'(timer_irq[2]), 64'd0);
        idle(1);
        chk("wrap_irq2_high", 64'(timer_irq[2]), 64'd1);
        idle(1);
        chk("wrap_irq2_drop", 64'(timer_irq[2]), 64'd0);

        // mtime write beats tick; high half holds (no carry)
        wr(8'h00, 32'hFFFF_FFFF);
        wr(8'h00, 32'h0000_1234);
        rd(8'h00);
        chk("mtime_lo_write_wins", 64'(rdata), 64'h1234);
        rd(8'h04);
        chk("mtime_hi_unchanged", 64'(rdata), 64'h0);
        rd(8'h50);
        chk("unmapped_read", 64'(rdata), 64'h0);

        // reset mid-operation with periodic pend set
        wr(8'h24, 32'h0);
        wr(8'h20, 32'd200);
        wr(8'h00, 32'd300);
        idle(2);
        chk("pre_reset_irq1", 64'(timer_irq[1]), 64'd1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_reset_irq", 64'(timer_irq), 64'd0);
        chk("async_reset_any", 64'(timer_irq_any), 64'd0);
        chk("async_reset_rdata", 64'(rdata), 64'd0);
        idle(2);
        #3 reset = 1'b1;
        rd(8'h00);
        chk("post_reset_mtime", 64'(rdata), 64'd0);
        rd(8'h20);
        chk("post_reset_cmp_lo", 64'(rdata), 64'hFFFF_FFFF);
        rd(8'h24);
        chk("post_reset_cmp_hi", 64'(rdata), 64'hFFFF_FFFF);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            halt = ($urandom_range(0, 9) == 0);
            ra = 8'($urandom_range(0, 23) * 4 + $urandom_range(0, 3));
            if (ra[7:2] == 6'h02)
                rw = 32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 3) != 0);
            else if ($urandom_range(0, 1) == 0)
                rw = 32'($urandom_range(0, 40));
            else
                rw = $urandom;
            if ($urandom_range(0, 9) < 6) cyc(1'b1, $urandom_range(0, 1) == 1, ra, rw);
            else idle(1);
        end
        halt = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
